// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C transfer arbiter: field widths, status bits,
// FSM state encodings and a small index-width helper.
package i2c_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int CNT_W  = 8;
    localparam int CTRL_W = 16;

    localparam int STATUS_NACK_BIT = 0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RELEASE   = 3'd4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_xfer_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns a one-hot winner and its index.
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      idx,
    output logic               found
);

    int   cand_s;
    logic hit_s;

    // Scan candidates in priority order starting from ptr; first hit wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand_s = 0;
        hit_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s         = int'(ptr) + i;
            cand_s         = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            hit_s          = req[cand_s] & ~found;
            winner[cand_s] = hit_s;
            idx            = hit_s ? IW'(cand_s) : idx;
            found          = found | hit_s;
        end
    end

endmodule

// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter that grants one requester at a time access to a shared
// I2C core, launches the transfer and reports done/err with a watchdog.
module i2c_xfer_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TO_W    = 20
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*CNT_W-1:0]  req_cnt,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [NUM_REQ-1:0]        err,
    output logic [ADDR_W-1:0]         tx_apb_addr,
    output logic [CNT_W-1:0]          tx_apb_data_cnt,
    output logic [CTRL_W-1:0]         tx_ctrl,
    output logic                      start,
    input  logic                      i2c_ready,
    input  logic [7:0]                status,
    input  logic [TO_W-1:0]           time_out
);

    localparam int IW = idx_width(NUM_REQ);

    logic [2:0]          state_r;
    logic [IW-1:0]       ptr_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [NUM_REQ-1:0]  done_r;
    logic [NUM_REQ-1:0]  err_r;
    logic                start_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CTRL_W-1:1]   ctrl_r;
    logic [TO_W-1:0]     wd_r;
    logic                wd_en_r;

    logic [NUM_REQ-1:0]  win_s;
    logic [IW-1:0]       win_idx_s;
    logic                found_s;
    logic [IW-1:0]       next_ptr_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [CNT_W-1:0]    sel_cnt_s;
    logic [CTRL_W-1:0]   sel_ctrl_s;
    logic                nack_s;
    logic                wd_expire_s;
    logic                unused_bits_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_r),
        .winner (win_s),
        .idx    (win_idx_s),
        .found  (found_s)
    );

    assign next_ptr_s  = (win_idx_s == IW'(NUM_REQ - 1)) ? '0 : (win_idx_s + IW'(1'b1));
    assign sel_addr_s  = req_addr[win_idx_s * ADDR_W +: ADDR_W];
    assign sel_cnt_s   = req_cnt[win_idx_s * CNT_W +: CNT_W];
    assign sel_ctrl_s  = req_ctrl[win_idx_s * CTRL_W +: CTRL_W];
    assign nack_s      = status[STATUS_NACK_BIT];
    // Bit 0 of the control word is owned by the launch strobe, not the requester.
    assign unused_bits_s = ^{status[7:1], sel_ctrl_s[0]};
    // Expiry only when armed with a non-zero reload; a zero reload never fires.
    assign wd_expire_s = wd_en_r && (wd_r <= TO_W'(1'b1));

    assign gnt             = gnt_r;
    assign done            = done_r;
    assign err             = err_r;
    assign start           = start_r;
    assign tx_apb_addr     = addr_r;
    assign tx_apb_data_cnt = cnt_r;
    assign tx_ctrl         = {ctrl_r, start_r};

    // Arbitration FSM, field latches, completion pulses and watchdog.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            err_r   <= '0;
            start_r <= 1'b0;
            addr_r  <= '0;
            cnt_r   <= '0;
            ctrl_r  <= '0;
            wd_r    <= '0;
            wd_en_r <= 1'b0;
        end else begin
            done_r  <= '0;
            err_r   <= '0;
            start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s && i2c_ready) begin
                        gnt_r   <= win_s;
                        ptr_r   <= next_ptr_s;
                        addr_r  <= sel_addr_s;
                        cnt_r   <= sel_cnt_s;
                        ctrl_r  <= sel_ctrl_s[CTRL_W-1:1];
                        state_r <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    start_r <= 1'b1;
                    wd_r    <= time_out;
                    wd_en_r <= |time_out;
                    state_r <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!i2c_ready) begin
                        wd_r    <= time_out;
                        state_r <= ST_WAIT_DONE;
                    end else if (wd_expire_s) begin
                        wd_r    <= '0;
                        err_r   <= gnt_r;
                        state_r <= ST_RELEASE;
                    end else if (wd_r != '0) begin
                        wd_r <= wd_r - TO_W'(1'b1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (i2c_ready) begin
                        if (nack_s) begin
                            err_r <= gnt_r;
                        end else begin
                            done_r <= gnt_r;
                        end
                        state_r <= ST_RELEASE;
                    end else if (wd_expire_s) begin
                        wd_r    <= '0;
                        err_r   <= gnt_r;
                        state_r <= ST_RELEASE;
                    end else if (wd_r != '0) begin
                        wd_r <= wd_r - TO_W'(1'b1);
                    end
                end
                ST_RELEASE: begin
                    gnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Directed bench for i2c_xfer_arbiter: grant order, latency, NACK, timeout,
// watchdog disable, asynchronous reset and latched-field stability.
module tb_i2c_xfer_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TO_W    = 20;

    logic        PCLK;
    logic        PRESETn;
    logic [3:0]  req;
    logic [35:0] req_addr;
    logic [31:0] req_cnt;
    logic [63:0] req_ctrl;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [8:0]  tx_apb_addr;
    logic [7:0]  tx_apb_data_cnt;
    logic [15:0] tx_ctrl;
    logic        start;
    logic        i2c_ready;
    logic [7:0]  status;
    logic [19:0] time_out;

    int errors = 0;
    int checks = 0;

    logic [8:0]  t_addr [4];
    logic [7:0]  t_cnt  [4];
    logic [15:0] t_ctrl [4];
    logic [3:0]  pulses;

    i2c_xfer_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TO_W    (TO_W)
    ) dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .req             (req),
        .req_addr        (req_addr),
        .req_cnt         (req_cnt),
        .req_ctrl        (req_ctrl),
        .gnt             (gnt),
        .done            (done),
        .err             (err),
        .tx_apb_addr     (tx_apb_addr),
        .tx_apb_data_cnt (tx_apb_data_cnt),
        .tx_ctrl         (tx_ctrl),
        .start           (start),
        .i2c_ready       (i2c_ready),
        .status          (status),
        .time_out        (time_out)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < 4; i++) begin
            req_addr[9*i +: 9]  = t_addr[i];
            req_cnt[8*i +: 8]   = t_cnt[i];
            req_ctrl[16*i +: 16] = t_ctrl[i];
        end
    endtask

    // One complete transfer for requester k, starting from IDLE with req[k] set.
    task automatic do_xfer(input int k, input logic nack, input logic scramble);
        logic [3:0]  oh;
        logic [8:0]  ea;
        logic [7:0]  ec;
        logic [15:0] ek;
        oh = 4'b0001 << k;
        ea = t_addr[k];
        ec = t_cnt[k];
        ek = t_ctrl[k];
        tick();
        check_val("xfer_gnt", gnt, oh);
        check_val("xfer_addr", tx_apb_addr, ea);
        check_val("xfer_cnt", tx_apb_data_cnt, ec);
        check_val("xfer_ctrl_pre", tx_ctrl, {ek[15:1], 1'b0});
        check_val("xfer_start_pre", start, 1'b0);
        if (scramble) begin
            req[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                t_addr[i] = ~t_addr[i];
                t_cnt[i]  = t_cnt[i] + 8'd16;
                t_ctrl[i] = ~t_ctrl[i];
            end
            drive_fields();
        end
        tick();
        check_val("xfer_start", start, 1'b1);
        check_val("xfer_ctrl_start", tx_ctrl, {ek[15:1], 1'b1});
        i2c_ready = 1'b0;
        tick();
        check_val("xfer_gnt_busy", gnt, oh);
        check_val("xfer_start_off", start, 1'b0);
        i2c_ready = 1'b1;
        status    = nack ? 8'hA5 : 8'hA4;
        tick();
        check_val("xfer_done", done, nack ? 4'b0000 : oh);
        check_val("xfer_err", err, nack ? oh : 4'b0000);
        check_val("xfer_addr_hold", tx_apb_addr, ea);
        check_val("xfer_cnt_hold", tx_apb_data_cnt, ec);
        tick();
        check_val("xfer_gnt_rel", gnt, 4'b0000);
        check_val("xfer_pulse_off", done | err, 4'b0000);
    endtask

    initial begin
        PRESETn   = 1'b0;
        req       = 4'b0000;
        i2c_ready = 1'b1;
        status    = 8'h00;
        time_out  = 20'd100;
        t_addr    = '{9'h0A2, 9'h0C4, 9'h1A0, 9'h0E7};
        t_cnt     = '{8'd1, 8'd2, 8'd4, 8'd9};
        t_ctrl    = '{16'h1234, 16'hF00F, 16'h5A5A, 16'h8001};
        drive_fields();
        tick();
        tick();
        check_val("rst_gnt", gnt, 4'b0000);
        check_val("rst_done_err", {done, err}, 8'h00);
        check_val("rst_start", start, 1'b0);
        check_val("rst_tx", {tx_apb_addr, tx_apb_data_cnt, tx_ctrl}, 33'h0);
        PRESETn = 1'b1;

        // All four requesting: order 0,1,2,3,0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_xfer(i % 4, 1'b0, 1'b0);
        end
        req = 4'b0000;

        // NACK on requester 1 (ptr is 1 after the wrap)
        req = 4'b0010;
        do_xfer(1, 1'b1, 1'b0);
        req = 4'b0000;

        // Single requester 2 with a slow core
        req = 4'b0100;
        tick();
        check_val("single_gnt", gnt, 4'b0100);
        check_val("single_addr", tx_apb_addr, 9'h1A0);
        check_val("single_cnt", tx_apb_data_cnt, 8'd4);
        check_val("single_start_p1", start, 1'b0);
        tick();
        check_val("single_start_p2", start, 1'b1);
        tick();
        check_val("single_start_p3", start, 1'b0);
        i2c_ready = 1'b0;
        pulses = 4'b0000;
        for (int c = 4; c <= 39; c++) begin
            tick();
            pulses = pulses | done | err;
        end
        check_val("single_no_early_pulse", pulses, 4'b0000);
        i2c_ready = 1'b1;
        status    = 8'h00;
        tick();
        check_val("single_done", done, 4'b0100);
        check_val("single_err", err, 4'b0000);
        req = 4'b0000;
        tick();
        check_val("single_gnt_rel", gnt, 4'b0000);

        // Timeout: core never leaves ready
        time_out = 20'd10;
        req = 4'b1000;
        tick();
        check_val("to_gnt", gnt, 4'b1000);
        tick();
        check_val("to_start", start, 1'b1);
        pulses = 4'b0000;
        for (int c = 3; c <= 11; c++) begin
            tick();
            pulses = pulses | done | err;
        end
        check_val("to_no_early_err", pulses, 4'b0000);
        tick();
        check_val("to_err", err, 4'b1000);
        check_val("to_done", done, 4'b0000);
        req = 4'b0000;
        tick();
        check_val("to_gnt_rel", gnt, 4'b0000);

        // Watchdog disabled with a zero reload
        time_out = 20'd0;
        req = 4'b0001;
        tick();
        check_val("wd0_gnt", gnt, 4'b0001);
        pulses = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            tick();
            pulses = pulses | done | err;
        end
        check_val("wd0_no_timeout", pulses, 4'b0000);
        check_val("wd0_gnt_held", gnt, 4'b0001);
        i2c_ready = 1'b0;
        tick();
        i2c_ready = 1'b1;
        tick();
        check_val("wd0_done", done, 4'b0001);
        req = 4'b0000;
        tick();
        time_out = 20'd100;

        // Reset while waiting for the core
        req = 4'b0100;
        tick();
        check_val("rst_mid_gnt", gnt, 4'b0100);
        tick();
        i2c_ready = 1'b0;
        tick();
        tick();
        #3;
        PRESETn = 1'b0;
        #1;
        check_val("rst_mid_gnt_clr", gnt, 4'b0000);
        check_val("rst_mid_tx_clr", {tx_apb_addr, tx_apb_data_cnt, tx_ctrl, start}, 34'h0);
        check_val("rst_mid_pulses", {done, err}, 8'h00);
        tick();
        PRESETn   = 1'b1;
        i2c_ready = 1'b1;
        req       = 4'b1111;
        do_xfer(0, 1'b0, 1'b0);
        req = 4'b0000;

        // Requester 1 drops mid-transfer while all fields change
        req = 4'b1010;
        do_xfer(1, 1'b0, 1'b1);
        check_val("drop_req_cleared", req, 4'b1000);
        do_xfer(3, 1'b0, 1'b0);
        req = 4'b0000;

        // Core busy in IDLE: request waits
        i2c_ready = 1'b0;
        req = 4'b0001;
        tick();
        tick();
        tick();
        check_val("busy_idle_no_gnt", gnt, 4'b0000);
        i2c_ready = 1'b1;
        do_xfer(0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
